// File: rtl/run_ctrl.sv
// Run controller for a simple fetch/decode/execute sequencer with a retired-instruction counter.
// Optional single-step support (PAUSE state, step_mode/step ports) is built when RUN_CTRL_STEP_EN is defined.
module run_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [1:0]       instruct,
`ifdef RUN_CTRL_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             fetch_en,
  output logic             exec_en,
  output logic             pc_inc,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
`ifdef RUN_CTRL_STEP_EN
    ,
    S_PAUSE  = 3'd5
`endif
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b10;

  state_t state;
  state_t state_nxt;

  // Handshake: the instruction register loads on any cycle where fetch_en is high;
  // there is no back-pressure, mem_ready alone qualifies the fetch.
  assign fetch_en  = (state == S_FETCH) && mem_ready;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (instruct == OP_HALT) ? S_HALT : S_EXEC;
`ifdef RUN_CTRL_STEP_EN
      S_EXEC:   state_nxt = step_mode ? S_PAUSE : S_FETCH;
      S_PAUSE:  if (step || !step_mode) state_nxt = S_FETCH;
`else
      S_EXEC:   state_nxt = S_FETCH;
`endif
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      retired <= '0;
      exec_en <= 1'b0;
      pc_inc  <= 1'b0;
      halted  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      if (state == S_EXEC) retired <= retired + CNT_W'(1);
      exec_en <= (state_nxt == S_EXEC);
      pc_inc  <= (state_nxt == S_EXEC);
      halted  <= (state_nxt == S_HALT);
      busy    <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
    end
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter CNT_W SHALL default to 16; it sets the width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock; it is the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin execution from IDLE.
REQ-005 mem_ready  input  1  instruction memory data is valid this cycle.
REQ-006 instruct  input  2  opcode from the instruction register, sampled in DECODE; 2'b10 = HALT, all other codes execute.
REQ-007 step_mode  input  1  enables pause after each instruction (RUN_CTRL_STEP_EN only).
REQ-008 step  input  1  single-cycle request to advance one instruction (RUN_CTRL_STEP_EN only).
REQ-009 fetch_en  output  1  loads the instruction register.
REQ-010 exec_en  output  1  one-cycle datapath execute strobe.
REQ-011 pc_inc  output  1  one-cycle program-counter increment.
REQ-012 halted  output  1  the processor is stopped on a HALT opcode.
REQ-013 busy  output  1  the controller is in FETCH, DECODE, EXEC or PAUSE.
REQ-014 retired  output  CNT_W  count of executed non-HALT instructions.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC and HALT, plus PAUSE when RUN_CTRL_STEP_EN is defined.
REQ-016 IDLE: if start=1, go to FETCH on the next edge; otherwise remain in IDLE.
REQ-017 FETCH: fetch_en = mem_ready (combinational from state); if mem_ready=1, go to DECODE; otherwise remain in FETCH (wait is unbounded).
REQ-018 DECODE: lasts one cycle; if instruct==2'b10, go to HALT; otherwise go to EXEC.
REQ-019 EXEC: lasts one cycle with exec_en=1 and pc_inc=1; retired increments on the same edge that leaves EXEC; next state is FETCH.
REQ-020 HALT: halted=1, busy=0, and exec_en, pc_inc and fetch_en stay 0; only reset exits HALT, and start is ignored.
REQ-021 A HALT opcode SHALL NOT increment retired or assert pc_inc.
REQ-022 A start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 retired SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-024 With mem_ready held high, the instruction period SHALL be exactly 3 cycles (FETCH, DECODE, EXEC); the first fetch_en occurs 1 cycle after start.
REQ-025 exec_en, pc_inc, halted and busy SHALL be Moore outputs decoded from state only.
REQ-026 At most one of fetch_en, exec_en and halted SHALL be high in any cycle.

Reset
REQ-027 When reset=1 at a rising edge, the next state SHALL be IDLE, retired SHALL be 0, and all outputs SHALL be 0 in the following cycle.
REQ-028 Reset SHALL take priority over start, step and mem_ready in every state, including mid-FETCH and HALT.
REQ-029 No output SHALL be X after the first reset edge.

Configuration
REQ-030 The macro RUN_CTRL_STEP_EN SHALL control single-step support.
REQ-031 With RUN_CTRL_STEP_EN defined: from EXEC, if step_mode=1, go to PAUSE instead of FETCH. In PAUSE, step=1 or step_mode=0 goes to FETCH; busy=1 and all strobes are 0.
REQ-032 Without RUN_CTRL_STEP_EN: the step_mode and step ports and the PAUSE state SHALL be absent, and EXEC always goes to FETCH.

Verification
REQ-033 Scenario: reset, start=1 for 1 cycle, mem_ready=1, instruct=2'b00 constant -> fetch_en pulses every 3 cycles starting 1 cycle after start; retired=5 after 15 cycles.
REQ-034 Scenario: instruct=2'b01 for 3 instructions, then 2'b10 -> retired=3, halted=1 permanently, no further pc_inc; start pulses in HALT are ignored.
REQ-035 Scenario: mem_ready=0 for 7 cycles in FETCH, then 1 -> fetch_en=0 for 7 cycles, high for exactly 1 cycle, then DECODE.
REQ-036 Scenario: reset=1 during EXEC with start=1 in the same cycle -> next cycle IDLE, retired=0, all outputs 0.
REQ-037 Scenario: CNT_W=4, 17 non-HALT instructions -> retired=1 after wrap.
REQ-038 Scenario (RUN_CTRL_STEP_EN): step_mode=1, two step pulses spaced 10 cycles apart -> exactly one exec_en per step, busy=1 throughout PAUSE.
